// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared neuron widths, quantiser and sequencer state encoding
package nn_pkg;

    localparam int NN_ACT_W  = 8;
    localparam int NN_WGT_W  = 8;
    localparam int NN_BIAS_W = 16;
    localparam int NN_PROD_W = 16;
    localparam int NN_ACC_W  = 23;
    localparam int NN_SHIFT  = 6;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        QUANT,
        DONE
    } seq_state_t;

    // ReLU, saturate to 127, round half-up on bit shift-1, clamp a rounded 128 back to 127.
    // The accumulator arrives sign-extended to 64 bits so any ACC_W up to 64 is handled.
    function automatic logic [7:0] quantise(input logic signed [63:0] acc, input int shift);
        logic [8:0] rounded;
        rounded  = '0;
        quantise = 8'd0;
        if (acc[63]) begin
            quantise = 8'd0;
        end else if ((acc >>> (shift + 7)) != 64'sd0) begin
            quantise = 8'd127;
        end else begin
            rounded  = {1'b0, acc[shift +: 8]} + 9'(acc[shift - 1]);
            quantise = (rounded > 9'd127) ? 8'd127 : rounded[7:0];
        end
    endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - registered signed 8x8 multiply-accumulate with bias load
module mac_unit
    import nn_pkg::*;
#(
    parameter int ACC_W = NN_ACC_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           load,
    input  logic signed [NN_ACT_W-1:0]     act,
    input  logic signed [NN_WGT_W-1:0]     wgt,
    input  logic signed [NN_BIAS_W-1:0]    bias,
    output logic signed [ACC_W-1:0]        acc
);

    logic signed [NN_PROD_W-1:0] act_x;
    logic signed [NN_PROD_W-1:0] wgt_x;
    logic signed [NN_PROD_W-1:0] product;
    logic signed [ACC_W-1:0]     prod_ext;
    logic signed [ACC_W-1:0]     bias_ext;

    assign act_x    = {{(NN_PROD_W-NN_ACT_W){act[NN_ACT_W-1]}}, act};
    assign wgt_x    = {{(NN_PROD_W-NN_WGT_W){wgt[NN_WGT_W-1]}}, wgt};
    assign product  = act_x * wgt_x;
    assign prod_ext = ACC_W'(product);
    assign bias_ext = ACC_W'(bias);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= load ? (bias_ext + prod_ext) : (acc + prod_ext);
        end
    end

endmodule

// File: rtl/layer_mac_sequencer.sv
// rtl/layer_mac_sequencer.sv - evaluates a dense layer one neuron at a time on a shared MAC
module layer_mac_sequencer
    import nn_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int N_OUT = 8,
    parameter int ACC_W = NN_ACC_W,
    parameter int SHIFT = NN_SHIFT,
    parameter int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    parameter int NA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*N_IN-1:0]     in_vec,
    output logic                  busy,
    output logic [WA_W-1:0]       w_addr,
    input  logic [7:0]            w_data,
    output logic [NA_W-1:0]       b_addr,
    input  logic [15:0]           b_data,
    output logic                  out_valid,
    output logic [NA_W-1:0]       out_idx,
    output logic [7:0]            out_data,
    output logic                  done
);

    localparam int KA_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    seq_state_t state, state_nxt;

    logic [NA_W-1:0]         n;
    logic [KA_W-1:0]         k;
    logic [KA_W-1:0]         k_d;
    logic                    data_valid_d;
    logic                    first_d;
    logic [8*N_IN-1:0]       in_bank;
    logic signed [7:0]       act;
    logic signed [ACC_W-1:0] acc;
    logic signed [63:0]      acc_ext;
    logic                    accept;
    logic                    last_k;
    logic                    last_n;

    // done is still high in the cycle after DONE; refusing start there keeps passes apart
    assign accept  = (state == IDLE) && start && !done;
    assign last_k  = (k == KA_W'(N_IN - 1));
    assign last_n  = (n == NA_W'(N_OUT - 1));
    assign act     = in_bank[8*k_d +: 8];
    assign acc_ext = 64'(acc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (last_k) state_nxt = DRAIN;
            DRAIN:   state_nxt = QUANT;
            QUANT:   state_nxt = last_n ? DONE : MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses run as counters so the ROM sees a gap-free 0..N_IN*N_OUT-1 sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            out_idx      <= '0;
            out_data     <= '0;
            w_addr       <= '0;
            b_addr       <= '0;
            n            <= '0;
            k            <= '0;
            k_d          <= '0;
            data_valid_d <= 1'b0;
            first_d      <= 1'b0;
            in_bank      <= '0;
        end else begin
            out_valid    <= 1'b0;
            done         <= 1'b0;
            data_valid_d <= (state == MAC);
            first_d      <= (state == MAC) && (k == '0);
            k_d          <= k;
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_bank <= in_vec;
                        n       <= '0;
                        k       <= '0;
                        w_addr  <= '0;
                        b_addr  <= '0;
                        busy    <= 1'b1;
                    end
                end
                MAC: begin
                    if (!last_k) begin
                        k      <= k + KA_W'(1);
                        w_addr <= w_addr + WA_W'(1);
                    end
                end
                QUANT: begin
                    out_data  <= quantise(acc_ext, SHIFT);
                    out_idx   <= n;
                    out_valid <= 1'b1;
                    if (!last_n) begin
                        n      <= n + NA_W'(1);
                        k      <= '0;
                        w_addr <= w_addr + WA_W'(1);
                        b_addr <= n + NA_W'(1);
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (data_valid_d),
        .load  (first_d),
        .act   (act),
        .wgt   (w_data),
        .bias  (b_data),
        .acc   (acc)
    );

endmodule

// File: doc/layer_mac_sequencer.md
Name: layer_mac_sequencer

Overview:
- Time-multiplexed replacement for a layer of fully-parallel neuron nodes: one shared signed 8x8 MAC evaluates N_OUT neurons of N_IN inputs each, in sequence.
- Weights and biases come from external synchronous ROMs with 1-cycle read latency.
- Quantisation is bit-exact with the parallel node: ReLU, saturate to 127, round on bit SHIFT-1.
- Sits between a layer's input activation register and the next layer's input; start/done handshake to the network controller.

Parameters:
- N_IN, 5, inputs per neuron (>=1)
- N_OUT, 8, neurons in layer (>=1)
- ACC_W, 23, accumulator width, signed
- SHIFT, 6, fractional bits dropped at quantisation
- WA_W, $clog2(N_IN*N_OUT), weight address width
- NA_W, $clog2(N_OUT) (min 1), neuron index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin layer pass; ignored while busy=1
- in_vec  in  8*N_IN  signed 8-bit activations, element k at [8k+7:8k]; sampled only in the start cycle
- busy  out  1  high from the cycle after an accepted start until done
- w_addr  out  WA_W  weight ROM address = neuron*N_IN + k
- w_data  in  8  signed weight, valid the cycle after w_addr
- b_addr  out  NA_W  bias ROM address = neuron index
- b_data  in  16  signed bias, valid the cycle after b_addr
- out_valid  out  1  one-cycle pulse per finished neuron
- out_idx  out  NA_W  neuron index of out_data
- out_data  out  8  quantised activation, 0..127
- done  out  1  one-cycle pulse after the last neuron's out_valid

Behaviour:
- Reset: state IDLE; busy, out_valid, done, out_idx, out_data, w_addr, b_addr, accumulator and input bank all 0. Reset mid-pass aborts with no further out_valid.
- IDLE: on start, latch in_vec into the input bank, clear neuron counter n and input counter k, and go to MAC. busy rises in the next cycle.
- MAC (N_IN cycles per neuron):
  - Each cycle drive w_addr = n*N_IN + k, then increment k.
  - On k=0 also drive b_addr = n.
  - After issuing k = N_IN-1, go to DRAIN.
- Data path, one cycle behind the address:
  - Product = sext16(in_bank[k_d]) * sext16(w_data), 16-bit signed.
  - The first data cycle of a neuron loads acc = sext(bias) + sext(product).
  - Later data cycles add sext(product) to acc.
  - All extensions are sign extensions to ACC_W; overflow wraps (cannot occur at defaults).
- DRAIN (1 cycle): the last product is accumulated; go to QUANT.
- QUANT (1 cycle), computing out_data:
  - If acc[ACC_W-1]=1: 0.
  - Else if acc[ACC_W-2:SHIFT+7] != 0: 127.
  - Else: acc[SHIFT+7:SHIFT] + acc[SHIFT-1], and a rounded result of 128 clamps to 127.
  - Register out_data, out_idx=n, out_valid=1 in the following cycle.
  - If n = N_OUT-1, go to DONE; else increment n, clear k, and return to MAC.
- DONE: done=1 for one cycle, busy=0 in the same cycle, go to IDLE.
- Throughput: one neuron per N_IN+2 cycles.
- Latency: start to done = 1 + N_OUT*(N_IN+2) + 1 cycles (58 at defaults). First out_valid arrives N_IN+3 cycles after start.
- start asserted in the DONE cycle is ignored; it is accepted only in IDLE.
- in_vec may change freely after the start cycle.

Decomposition:
- Shared package nn_pkg: activation/weight/bias widths (8/8/16), ACC_W, SHIFT, the quantise function (ReLU/saturate/round/clamp) shared with the parallel node generator, and the state enum {IDLE, MAC, DRAIN, QUANT, DONE}.
- One sub-module: mac_unit (registered signed multiply-accumulate with load/accumulate select). The FSM and counters stay in the top module.

Test Plan:
1. Nominal:
   - Stimulus: in_vec all 10; neuron 0 weights {62,12,-20,62,-62}, bias 512.
   - Required: acc 1052, out_valid with out_idx=0, out_data=16.
2. Saturation:
   - Stimulus: all inputs 127, all weights 127, bias 0 (acc 80645).
   - Required: out_data=127.
   - Separately: acc=8191, bits[13:6]=127 with bit5=1, must clamp to 127, not 128.
3. Negative and rounding:
   - Stimulus: bias -1 with zero weights.
   - Required: 0.
   - Separately: input0=1, w0=96, rest 0, bias 0.
   - Required: out_data=2 (round up).
4. Full pass timing with defaults:
   - Required: exactly 8 out_valid pulses with out_idx 0..7, spaced 7 cycles apart.
   - Required: done exactly 58 cycles after start; w_addr sequence 0..39 with no gaps or repeats.
5. Handshake:
   - Stimulus: start pulsed while busy, and again in the DONE cycle.
   - Required: both ignored, no extra pass. start one cycle after done begins a new pass.
6. Reset mid-pass:
   - Stimulus: reset during neuron 3.
   - Required: all outputs 0 next cycle, no further out_valid/done. A new start produces correct results from neuron 0.
